// File: rtl/seg_display_mux_if.sv
// seg_display_mux_if: conversion handshake, display controls and panel pin outputs.
interface seg_display_mux_if #(
    parameter int VALUE_W = 20,
    parameter int NUM_DIGITS = 4
);
    logic [VALUE_W-1:0] value;
    logic load;
    logic busy;
    logic [2:0] window;
    logic [3:0] dp_pos;
    logic [2:0] cursor;
    logic cursor_en;
    logic blank_lz;
    logic [6:0] seg;
    logic [NUM_DIGITS-1:0] an;
    logic dp;
    modport master (
        output value, load, window, dp_pos, cursor, cursor_en, blank_lz,
        input busy, seg, an, dp
    );
    modport slave (
        input value, load, window, dp_pos, cursor, cursor_en, blank_lz,
        output busy, seg, an, dp
    );
endinterface

// File: rtl/seg_display_mux.sv
// seg_display_mux: sequential binary-to-BCD converter feeding a scrolling, blanking,
// blinking multiplexed 7-segment display driver.
module seg_display_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W = 20,
    parameter int BCD_DIGITS = 6,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_SLOTS = 256
) (
    input logic clk,
    input logic rst,
    seg_display_mux_if.slave bus
);
    localparam int BW = BCD_DIGITS * 4;
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int KW = BLINK_SLOTS > 1 ? $clog2(BLINK_SLOTS) : 1;
    localparam int CW = $clog2(VALUE_W + 1);
    localparam logic [63:0] MAX_VAL = 64'(10 ** BCD_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t state, state_next;
    logic start;
    logic [VALUE_W-1:0] start_value, shift_reg, pend_value;
    logic pend_valid;
    logic [BW-1:0] bcd, bcd_adj, disp_bcd;
    logic [CW-1:0] bit_cnt;
    logic ovf_next, disp_ovf;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_next;

    // A load arriving in the COMMIT cycle is newer than anything pending, so it wins.
    always_comb begin
        start = (state == IDLE && bus.load) || (state == COMMIT && (bus.load || pend_valid));
        start_value = bus.load ? bus.value : pend_value;
        state_next = start ? SHIFT :
                     state == SHIFT && bit_cnt == CW'(VALUE_W - 1) ? COMMIT :
                     state == COMMIT ? IDLE : state;
    end

    assign bus.busy = state != IDLE;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pend_valid <= 1'b0;
            pend_value <= '0;
        end else if (start) begin
            pend_valid <= 1'b0;
        end else if (bus.load && state != IDLE) begin
            pend_valid <= 1'b1;
            pend_value <= bus.value;
        end

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
        assign bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] >= 4'd5 ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            shift_reg <= '0;
            bcd <= '0;
            bit_cnt <= '0;
            ovf_next <= 1'b0;
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
        end else begin
            if (start) begin
                shift_reg <= start_value;
                bcd <= '0;
                bit_cnt <= '0;
                ovf_next <= 64'(start_value) > MAX_VAL;
            end else if (state == SHIFT) begin
                {bcd, shift_reg} <= {bcd_adj[BW-2:0], shift_reg, 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == COMMIT) begin
                disp_bcd <= bcd;
                disp_ovf <= ovf_next;
            end
        end

    logic [RW-1:0] rc, rc_next;
    logic [SW-1:0] slot, slot_next;
    logic [KW-1:0] blink_cnt;
    logic blink_phase, rc_wrap, slot_wrap;

    assign rc_wrap = rc == RW'(REFRESH_DIV - 1);
    assign slot_wrap = slot == SW'(NUM_DIGITS - 1);
    assign rc_next = rc_wrap ? '0 : rc + 1'b1;
    assign slot_next = !rc_wrap ? slot : slot_wrap ? '0 : slot + 1'b1;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rc <= '0;
            slot <= '0;
            blink_cnt <= '0;
            blink_phase <= 1'b0;
        end else begin
            rc <= rc_next;
            slot <= slot_next;
            if (rc_wrap && slot_wrap) begin
                blink_cnt <= blink_cnt == KW'(BLINK_SLOTS - 1) ? '0 : blink_cnt + 1'b1;
                if (blink_cnt == KW'(BLINK_SLOTS - 1)) blink_phase <= ~blink_phase;
            end
        end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    logic [4:0] a;
    logic [3:0] nib;
    logic [2:0] hi;
    logic oor, lz, cur, dp_d;
    logic [6:0] seg_d;
    logic [NUM_DIGITS-1:0] an_d;

    // Decoded from the next counter values so the registered pins line up with the slot,
    // and the anodes go dark exactly in the last cycle of each slot.
    always_comb begin
        a = 5'(bus.window) + 5'(slot_next);
        nib = 4'(disp_bcd >> {a, 2'b00});
        hi = '0;
        for (int i = 1; i < BCD_DIGITS; i++) if (disp_bcd[i*4 +: 4] != 4'd0) hi = 3'(i);
        oor = a >= 5'(BCD_DIGITS);
        lz = bus.blank_lz && a > 5'(hi);
        cur = bus.cursor_en && a == 5'(bus.cursor) && blink_phase;
        seg_d = oor ? 7'h7F : disp_ovf ? 7'b0111111 : lz || cur ? 7'h7F : glyph(nib);
        dp_d = oor || disp_ovf || a != 5'(bus.dp_pos);
        an_d = rc_next == RW'(REFRESH_DIV - 1) ? '1 : ~(NUM_DIGITS'(1) << slot_next);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.seg <= 7'h7F;
            bus.an <= '1;
            bus.dp <= 1'b1;
        end else begin
            bus.seg <= seg_d;
            bus.an <= an_d;
            bus.dp <= dp_d;
        end
endmodule
